x_driver_burst: RTL and testbench

Parametrised byte-command driver: host bytes arriving on a valid-only RX stream load nibbles into a BYTES-wide shift register. Unload commands stream a programmable burst of bytes out, MSB first, over a valid/accept TX handshake. It is the successor of the single-byte nibble driver and sits between the UART RX byte stream and the delay-line write port.

---
 rtl/x_driver_burst.sv | 117 +++++++++++
 tb/tb_x_driver_burst.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/x_driver_burst.sv
// x_driver_burst: byte-command driver. RX command bytes load nibbles into a
// BYTES-wide shift register; UNLOAD streams a burst of bytes out MSB first.
//
// Optional feature macro: X_DRIVER_BURST_ROTATE_EN
//   defined   - each transfer rotates data_q left by one byte. A full burst
//               leaves the payload intact so it can be replayed.
//   undefined - each transfer shifts data_q left and zero-fills the bottom byte.
//
// Handshake: RX is valid-only (i_valid qualifies i_data for exactly one cycle,
// no backpressure). TX is valid/accept: a byte transfers in a cycle where
// o_valid & i_accept are both high; o_data is held stable while o_valid is
// high and no transfer occurs. i_accept is ignored while o_valid is low.
module x_driver_burst #(
  parameter int BYTES = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_valid,
  input  logic [7:0] i_data,
  output logic       o_valid,
  input  logic       i_accept,
  output logic [7:0] o_data,
  output logic       o_busy,
  output logic       o_drop,
  output logic       o_dbg_state
);

  localparam int W = 8 * BYTES;
  localparam logic [4:0] BYTES_C = 5'(BYTES);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t         state_q;
  logic [W-1:0]   data_q;
  logic [4:0]     cnt_q;

  logic [3:0]     opcode;
  logic [3:0]     arg;
  logic           is_load;
  logic           is_unload;
  logic           is_clear;
  logic           is_cmd;
  logic [4:0]     burst_len;
  logic [W-1:0]   shifted;

  assign opcode = i_data[3:0];
  assign arg    = i_data[7:4];

  // Command decode, burst length clamp and the per-transfer register update.
  always_comb begin
    is_load   = i_valid && (opcode == 4'h0);
    is_unload = i_valid && (opcode == 4'h1);
    is_clear  = i_valid && (opcode == 4'h2);
    is_cmd    = is_load || is_unload || is_clear;

    burst_len = BYTES_C;
    if (arg != 4'h0 && {1'b0, arg} < BYTES_C) begin
      burst_len = {1'b0, arg};
    end

`ifdef X_DRIVER_BURST_ROTATE_EN
    shifted = {data_q[W-9:0], data_q[W-1:W-8]};
`else
    shifted = {data_q[W-9:0], 8'h00};
`endif
  end

  // Main FSM: IDLE executes commands, SEND streams the burst and drops commands.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      o_valid <= 1'b0;
      o_drop  <= 1'b0;
    end else begin
      o_drop <= 1'b0;
      case (state_q)
        IDLE: begin
          if (is_load) begin
            data_q <= {data_q[W-5:0], arg};
          end else if (is_clear) begin
            data_q <= '0;
          end else if (is_unload) begin
            cnt_q   <= burst_len;
            o_valid <= 1'b1;
            state_q <= SEND;
          end
        end
        SEND: begin
          // A command landing on the final transfer is still seen in SEND.
          o_drop <= is_cmd;
          if (i_accept) begin
            data_q <= shifted;
            cnt_q  <= cnt_q - 5'd1;
            if (cnt_q == 5'd1) begin
              o_valid <= 1'b0;
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          o_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_data      = data_q[W-1 -: 8];
  assign o_busy      = o_valid;
  assign o_dbg_state = (state_q == SEND);

endmodule

// File: tb/tb_x_driver_burst.sv
// tb_x_driver_burst: directed vector table for x_driver_burst (BYTES=4),
// plus a hand-written asynchronous-reset-mid-burst sequence.
module tb_x_driver_burst;

`ifdef X_DRIVER_BURST_ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       accept;
  logic       out_valid;
  logic [7:0] out_data;
  logic       busy;
  logic       drop;
  logic       dbg_state;

  int n_vec  = 0;
  int n_miss = 0;

  x_driver_burst #(.BYTES(4)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_valid     (in_valid),
    .i_data      (in_data),
    .o_valid     (out_valid),
    .i_accept    (accept),
    .o_data      (out_data),
    .o_busy      (busy),
    .o_drop      (drop),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       a;
    logic       ev;
    logic [7:0] ed;
    logic       edp;
  } vec_t;

  vec_t vq[$];

  function automatic void add(input logic v, input logic [7:0] d, input logic a,
                              input logic ev, input logic [7:0] ed, input logic edp);
    vec_t t;
    t.v = v; t.d = d; t.a = a; t.ev = ev; t.ed = ed; t.edp = edp;
    vq.push_back(t);
  endfunction

  // Eight LOADs of nibbles 1..8 into a cleared register.
  function automatic void add_loads();
    for (int i = 0; i < 8; i++) begin
      add(1'b1, 8'((i + 1) << 4), 1'b0, 1'b0, (i == 7) ? 8'h01 : 8'h00, 1'b0);
    end
  endfunction

  function automatic logic [7:0] rv(input logic [7:0] rot_val);
    return ROT ? rot_val : 8'h00;
  endfunction

  // scoreboard compare of all outputs against expectations
  task automatic check(input string name, input int idx, input logic ev,
                       input logic [7:0] ed, input logic edp);
    logic [10:0] got;
    logic [10:0] exp_v;
    got   = {out_valid, busy, drop, out_data};
    exp_v = {ev, ev, edp, ed};
    n_vec++;
    if (got !== exp_v) begin
      n_miss++;
      $display("FAIL %s #%0d: got valid=%b busy=%b drop=%b data=%h, want valid=%b busy=%b drop=%b data=%h",
               name, idx, out_valid, busy, drop, out_data, ev, ev, edp, ed);
    end
  endtask

  // driver: apply inputs for one cycle; outputs checked mid-cycle
  task automatic apply(input string name, input int idx, input logic v, input logic [7:0] d,
                       input logic a, input logic ev, input logic [7:0] ed, input logic edp);
    @(negedge clk);
    in_valid = v;
    in_data  = d;
    accept   = a;
    check(name, idx, ev, ed, edp);
  endtask

  initial begin
    logic [3:0] nibs [8];

    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    accept   = 1'b0;

    // A: load 0x12345678, full burst (arg 0) with accept held high
    add_loads();
    add(1'b1, 8'h01, 1'b1, 1'b0, 8'h12, 1'b0);
    add(1'b0, 8'h00, 1'b1, 1'b1, 8'h12, 1'b0);
    add(1'b0, 8'h00, 1'b1, 1'b1, 8'h34, 1'b0);
    add(1'b0, 8'h00, 1'b1, 1'b1, 8'h56, 1'b0);
    add(1'b0, 8'h00, 1'b1, 1'b1, 8'h78, 1'b0);
    // B: arg 2 with a stall, then drain remainder to see the low bytes
    add(1'b1, 8'h02, 1'b0, 1'b0, rv(8'h12), 1'b0);
    add_loads();
    add(1'b1, 8'h21, 1'b0, 1'b0, 8'h12, 1'b0);
    add(1'b0, 8'h00, 1'b1, 1'b1, 8'h12, 1'b0);
    add(1'b0, 8'h00, 1'b0, 1'b1, 8'h34, 1'b0);
    add(1'b0, 8'h00, 1'b1, 1'b1, 8'h34, 1'b0);
    add(1'b1, 8'h01, 1'b0, 1'b0, 8'h56, 1'b0);
    add(1'b0, 8'h00, 1'b1, 1'b1, 8'h56, 1'b0);
    add(1'b0, 8'h00, 1'b1, 1'b1, 8'h78, 1'b0);
    add(1'b0, 8'h00, 1'b1, 1'b1, rv(8'h12), 1'b0);
    add(1'b0, 8'h00, 1'b1, 1'b1, rv(8'h34), 1'b0);
    // C: commands during a burst are dropped, including on the final transfer
    add(1'b1, 8'h02, 1'b0, 1'b0, rv(8'h56), 1'b0);
    add_loads();
    add(1'b1, 8'h01, 1'b1, 1'b0, 8'h12, 1'b0);
    add(1'b1, 8'hF0, 1'b1, 1'b1, 8'h12, 1'b0);
    add(1'b1, 8'h02, 1'b1, 1'b1, 8'h34, 1'b1);
    add(1'b0, 8'h00, 1'b1, 1'b1, 8'h56, 1'b1);
    add(1'b1, 8'h01, 1'b1, 1'b1, 8'h78, 1'b0);
    add(1'b1, 8'h07, 1'b0, 1'b0, rv(8'h12), 1'b1);
    // D: arg 9 clamps to 4; opcode 7 ignored in both states, no drop
    add(1'b1, 8'h02, 1'b0, 1'b0, rv(8'h12), 1'b0);
    add_loads();
    add(1'b1, 8'h91, 1'b1, 1'b0, 8'h12, 1'b0);
    add(1'b1, 8'h07, 1'b1, 1'b1, 8'h12, 1'b0);
    add(1'b0, 8'h00, 1'b1, 1'b1, 8'h34, 1'b0);
    add(1'b0, 8'h00, 1'b1, 1'b1, 8'h56, 1'b0);
    add(1'b0, 8'h00, 1'b1, 1'b1, 8'h78, 1'b0);
    // E: accept pulses while idle do not shift the register
    add(1'b1, 8'h02, 1'b0, 1'b0, rv(8'h12), 1'b0);
    add_loads();
    add(1'b0, 8'h00, 1'b1, 1'b0, 8'h12, 1'b0);
    add(1'b0, 8'h00, 1'b1, 1'b0, 8'h12, 1'b0);
    add(1'b0, 8'h00, 1'b1, 1'b0, 8'h12, 1'b0);
    add(1'b1, 8'h01, 1'b1, 1'b0, 8'h12, 1'b0);
    add(1'b0, 8'h00, 1'b1, 1'b1, 8'h12, 1'b0);
    add(1'b0, 8'h00, 1'b1, 1'b1, 8'h34, 1'b0);
    add(1'b0, 8'h00, 1'b1, 1'b1, 8'h56, 1'b0);
    add(1'b0, 8'h00, 1'b1, 1'b1, 8'h78, 1'b0);
    // F: start a burst, two transfers, then reset by hand below
    add(1'b1, 8'h02, 1'b0, 1'b0, rv(8'h12), 1'b0);
    add_loads();
    add(1'b1, 8'h01, 1'b1, 1'b0, 8'h12, 1'b0);
    add(1'b0, 8'h00, 1'b1, 1'b1, 8'h12, 1'b0);
    add(1'b0, 8'h00, 1'b1, 1'b1, 8'h34, 1'b0);

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset", 0, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      apply("vec", i, vq[i].v, vq[i].d, vq[i].a, vq[i].ev, vq[i].ed, vq[i].edp);
    end

    // Asynchronous reset mid-burst: outputs clear without a clock edge
    @(posedge clk);
    #2;
    check("pre_rst", 0, 1'b1, 8'h56, 1'b0);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    accept   = 1'b0;
    #1;
    check("async_rst", 0, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // After release the block is IDLE and takes LOADs: nibbles A,B,C,D,E,F,1,2
    nibs = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h1, 4'h2};
    for (int i = 0; i < 8; i++) begin
      apply("post_rst_load", i, 1'b1, {nibs[i], 4'h0}, 1'b0, 1'b0,
            (i == 7) ? 8'h0A : 8'h00, 1'b0);
    end
    apply("post_rst_top", 0, 1'b0, 8'h00, 1'b0, 1'b0, 8'hAB, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
